// File: rtl/scrambler_pipe.sv
// scrambler_pipe: additive LFSR (de)scrambler, DATA_BYTES lanes per beat,
// registered AXI-stream output. SCRAMBLER_PIPE_SKID_EN selects 2-entry skid.
//
// Ports:
//   clk, rst (async, active-high)
//   s_axis_{valid,ready,data,last,sop,is_parity} : input beat stream
//   m_axis_{valid,ready,data,last,sop,is_parity} : scrambled beat stream
// Build option: define SCRAMBLER_PIPE_SKID_EN for the skid-buffer output
// stage with a registered s_axis_ready; default is one output register.
`timescale 1ns/1ps

module scrambler_pipe #(
  parameter int                  DATA_BYTES      = 1,
  parameter int                  LFSR_LEN        = 7,
  parameter logic [LFSR_LEN-1:0] TAPS            = 7'b0001001,
  parameter logic [LFSR_LEN-1:0] SEED            = 7'b1011101,
  parameter bit                  SCRAMBLE_PARITY = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    s_axis_valid,
  output logic                    s_axis_ready,
  input  logic [8*DATA_BYTES-1:0] s_axis_data,
  input  logic                    s_axis_last,
  input  logic                    s_axis_sop,
  input  logic                    s_axis_is_parity,
  output logic                    m_axis_valid,
  input  logic                    m_axis_ready,
  output logic [8*DATA_BYTES-1:0] m_axis_data,
  output logic                    m_axis_last,
  output logic                    m_axis_sop,
  output logic                    m_axis_is_parity
);

  localparam int W  = 8 * DATA_BYTES;
  localparam int PW = W + 3;

  logic [LFSR_LEN-1:0] lfsr_q;
  logic [LFSR_LEN-1:0] lfsr_d;
  logic [LFSR_LEN-1:0] start_st;
  logic [LFSR_LEN-1:0] adv_st;
  logic [W-1:0]        ks;
  logic [W-1:0]        beat_data;
  logic [PW-1:0]       beat_in;
  logic [PW-1:0]       main_q;
  logic                m_valid_q;
  logic                bypass;
  logic                accept;

  assign accept = s_axis_valid && s_axis_ready;

  // SOP reseeds the beat that carries it, not the following one.
  assign start_st = s_axis_sop ? SEED : lfsr_q;

  // Unrolled keystream: lane 0 first, MSB first within each lane.
  always_comb begin
    adv_st = start_st;
    ks     = '0;
    for (int l = 0; l < DATA_BYTES; l++) begin
      for (int b = 7; b >= 0; b--) begin
        ks[l*8+b] = adv_st[0];
        adv_st = {adv_st[LFSR_LEN-2:0], ^(adv_st & TAPS)};
      end
    end
  end

  // Unscrambled parity beats neither use nor consume keystream.
  assign bypass    = (SCRAMBLE_PARITY == 1'b0) && s_axis_is_parity;
  assign beat_data = bypass ? s_axis_data : (s_axis_data ^ ks);
  assign lfsr_d    = bypass ? start_st : adv_st;
  assign beat_in   = {s_axis_last, s_axis_sop, s_axis_is_parity, beat_data};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= SEED;
    end else if (accept) begin
      lfsr_q <= lfsr_d;
    end
  end

  assign m_axis_valid = m_valid_q;
  assign {m_axis_last, m_axis_sop, m_axis_is_parity, m_axis_data} = main_q;

`ifdef SCRAMBLER_PIPE_SKID_EN
  logic [PW-1:0] skid_q;
  logic          skid_vld;

  // Ready only looks at our own register, never at m_axis_ready.
  assign s_axis_ready = !skid_vld;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid_q <= 1'b0;
      main_q    <= '0;
      skid_q    <= '0;
      skid_vld  <= 1'b0;
    end else if (!m_valid_q || m_axis_ready) begin
      if (skid_vld) begin
        main_q    <= skid_q;
        m_valid_q <= 1'b1;
        skid_vld  <= 1'b0;
      end else begin
        m_valid_q <= accept;
        if (accept) begin
          main_q <= beat_in;
        end
      end
    end else if (accept) begin
      // Output stalled: park the beat that arrived under a stale ready.
      skid_q   <= beat_in;
      skid_vld <= 1'b1;
    end
  end
`else
  assign s_axis_ready = !m_valid_q || m_axis_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid_q <= 1'b0;
      main_q    <= '0;
    end else if (s_axis_ready) begin
      m_valid_q <= s_axis_valid;
      if (s_axis_valid) begin
        main_q <= beat_in;
      end
    end
  end
`endif

endmodule

// File: tb/tb_scrambler_pipe.sv
// tb_scrambler_pipe: randomized self-checking bench for scrambler_pipe
// against a bytewise behavioural LFSR model.
`timescale 1ns/1ps

module tb_scrambler_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic       s_valid, s_ready, s_last, s_sop, s_par;
  logic       m_valid, m_ready, m_last, m_sop, m_par;
  logic [7:0] s_data, m_data;

  logic        a_valid, a_ready, a_last, a_sop, a_par;
  logic        x_valid, x_ready, x_last, x_sop, x_par;
  logic        b_valid, b_ready, b_last, b_sop, b_par;
  logic [15:0] a_data, x_data, b_data;

  logic       p_valid, p_ready, p_last, p_sop, p_par;
  logic       q_valid, q_ready, q_last, q_sop, q_par;
  logic [7:0] p_data, q_data;

  int errors = 0;
  int checks = 0;
  localparam int unsigned SEED_I = 93;
  int unsigned st_ref = SEED_I;
  int unsigned st2_ref = SEED_I;

  scrambler_pipe dut (
    .clk(clk), .rst(rst),
    .s_axis_valid(s_valid), .s_axis_ready(s_ready),
    .s_axis_data(s_data), .s_axis_last(s_last),
    .s_axis_sop(s_sop), .s_axis_is_parity(s_par),
    .m_axis_valid(m_valid), .m_axis_ready(m_ready),
    .m_axis_data(m_data), .m_axis_last(m_last),
    .m_axis_sop(m_sop), .m_axis_is_parity(m_par)
  );

  scrambler_pipe #(.DATA_BYTES(2)) dut2 (
    .clk(clk), .rst(rst),
    .s_axis_valid(a_valid), .s_axis_ready(a_ready),
    .s_axis_data(a_data), .s_axis_last(a_last),
    .s_axis_sop(a_sop), .s_axis_is_parity(a_par),
    .m_axis_valid(x_valid), .m_axis_ready(x_ready),
    .m_axis_data(x_data), .m_axis_last(x_last),
    .m_axis_sop(x_sop), .m_axis_is_parity(x_par)
  );

  scrambler_pipe #(.DATA_BYTES(2)) dut2b (
    .clk(clk), .rst(rst),
    .s_axis_valid(x_valid), .s_axis_ready(x_ready),
    .s_axis_data(x_data), .s_axis_last(x_last),
    .s_axis_sop(x_sop), .s_axis_is_parity(x_par),
    .m_axis_valid(b_valid), .m_axis_ready(b_ready),
    .m_axis_data(b_data), .m_axis_last(b_last),
    .m_axis_sop(b_sop), .m_axis_is_parity(b_par)
  );

  scrambler_pipe #(.SCRAMBLE_PARITY(1'b0)) dutp (
    .clk(clk), .rst(rst),
    .s_axis_valid(p_valid), .s_axis_ready(p_ready),
    .s_axis_data(p_data), .s_axis_last(p_last),
    .s_axis_sop(p_sop), .s_axis_is_parity(p_par),
    .m_axis_valid(q_valid), .m_axis_ready(q_ready),
    .m_axis_data(q_data), .m_axis_last(q_last),
    .m_axis_sop(q_sop), .m_axis_is_parity(q_par)
  );

  // One keystream byte: MSB gets the first generated bit.
  task automatic ks_byte(inout int unsigned st, output logic [7:0] k);
    int unsigned fb;
    for (int i = 7; i >= 0; i--) begin
      k[i] = ((st % 2) == 1);
      fb = $countones(st & 32'h9) % 2;
      st = (st * 2 + fb) % 128;
    end
  endtask

  task automatic ref_main(input logic [7:0] d, input logic sop,
                          output logic [7:0] e);
    logic [7:0] k;
    if (sop) st_ref = SEED_I;
    ks_byte(st_ref, k);
    e = d ^ k;
  endtask

  task automatic ref_wide(input logic [15:0] d, input logic sop,
                          output logic [15:0] e);
    logic [7:0] k0, k1;
    if (sop) st2_ref = SEED_I;
    ks_byte(st2_ref, k0);
    ks_byte(st2_ref, k1);
    e = d ^ {k1, k0};
  endtask

  task automatic test_reset;
    rst = 1'b1;
    {s_valid, s_last, s_sop, s_par, s_data} = '0;
    {a_valid, a_last, a_sop, a_par, a_data} = '0;
    {p_valid, p_last, p_sop, p_par, p_data} = '0;
    m_ready = 1'b1; b_ready = 1'b1; q_ready = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (m_valid !== 1'b0) begin
      errors++; $display("FAIL reset_m_valid got=%b exp=0", m_valid);
    end
    checks++;
    if ({m_last, m_sop, m_par, m_data} !== 11'h0) begin
      errors++;
      $display("FAIL reset_m_out got=%h exp=0", {m_last, m_sop, m_par, m_data});
    end
    checks++;
    if (s_ready !== 1'b1) begin
      errors++; $display("FAIL reset_s_ready got=%b exp=1", s_ready);
    end
    checks++;
    if (dut.lfsr_q !== 7'b1011101) begin
      errors++; $display("FAIL reset_lfsr got=%b exp=1011101", dut.lfsr_q);
    end
    rst = 1'b0;
    st_ref = SEED_I;
    st2_ref = SEED_I;
  endtask

  task automatic test_basic;
    @(negedge clk);
    s_valid = 1'b1; s_data = 8'h00; s_sop = 1'b1; s_last = 1'b0;
    @(negedge clk);
    checks++;
    if (m_valid !== 1'b1 || m_data !== 8'hB2 || m_sop !== 1'b1) begin
      errors++;
      $display("FAIL basic_b0 got v=%b d=%h sop=%b exp v=1 d=b2 sop=1",
               m_valid, m_data, m_sop);
    end
    s_sop = 1'b0; s_last = 1'b1;
    @(negedge clk);
    checks++;
    if (m_valid !== 1'b1 || m_data !== 8'h3D || m_last !== 1'b1 ||
        m_sop !== 1'b0) begin
      errors++;
      $display("FAIL basic_b1 got v=%b d=%h last=%b exp v=1 d=3d last=1",
               m_valid, m_data, m_last);
    end
    s_valid = 1'b0; s_last = 1'b0;
    @(negedge clk);
    checks++;
    if (m_valid !== 1'b0) begin
      errors++; $display("FAIL basic_drain got=%b exp=0", m_valid);
    end
    checks++;
    if (dut.lfsr_q !== 7'b1111010) begin
      errors++; $display("FAIL basic_lfsr got=%b exp=1111010", dut.lfsr_q);
    end
    st_ref = 122;
  endtask

  task automatic test_sop_mid;
    logic [7:0] exp_q[$];
    logic [7:0] e, want;
    for (int i = 0; i <= 8; i++) begin
      @(negedge clk);
      if (i > 0) begin
        want = exp_q.pop_front();
        checks++;
        if (m_valid !== 1'b1 || m_data !== want) begin
          errors++;
          $display("FAIL sop_mid_b%0d got=%h exp=%h", i - 1, m_data, want);
        end
        if (i - 1 == 5 || i - 1 == 6) begin
          checks++;
          if (m_data !== ((i - 1 == 5) ? 8'hB2 : 8'h3D)) begin
            errors++;
            $display("FAIL sop_mid_const_b%0d got=%h", i - 1, m_data);
          end
        end
      end
      if (i < 8) begin
        s_valid = 1'b1; s_data = 8'h00;
        s_sop = (i == 0 || i == 5); s_last = (i == 7);
        ref_main(s_data, s_sop, e);
        exp_q.push_back(e);
      end else begin
        s_valid = 1'b0; s_sop = 1'b0; s_last = 1'b0;
      end
    end
  endtask

  task automatic test_parity_bypass;
    logic [7:0] din [3];
    logic [7:0] dexp [3];
    din[0] = 8'h00; din[1] = 8'hAA; din[2] = 8'h00;
    dexp[0] = 8'hB2; dexp[1] = 8'hAA; dexp[2] = 8'h3D;
    for (int i = 0; i <= 3; i++) begin
      @(negedge clk);
      if (i > 0) begin
        checks++;
        if (q_valid !== 1'b1 || q_data !== dexp[i-1] ||
            q_par !== (i == 2)) begin
          errors++;
          $display("FAIL parity_b%0d got v=%b d=%h par=%b exp d=%h",
                   i - 1, q_valid, q_data, q_par, dexp[i-1]);
        end
      end
      if (i < 3) begin
        p_valid = 1'b1; p_data = din[i];
        p_sop = (i == 0); p_par = (i == 1); p_last = (i == 2);
      end else begin
        {p_valid, p_sop, p_par, p_last} = '0;
      end
    end
  endtask

  task automatic test_round_trip;
    logic [15:0] raw_q[$];
    logic [15:0] scr_q[$];
    logic [15:0] cur, e, want;
    logic have, first_done;
    int fidx, bidx, flen, cyc;
    have = 1'b0; first_done = 1'b0;
    fidx = 0; bidx = 0; flen = 1; cyc = 0;
    while ((fidx < 1000 || have || raw_q.size() > 0 || scr_q.size() > 0)
           && cyc < 20000) begin
      cyc++;
      @(negedge clk);
      if (!have && fidx < 1000) begin
        if (bidx == 0) flen = $urandom_range(1, 3);
        a_sop = (bidx == 0);
        a_last = (bidx == flen - 1);
        cur = (fidx == 0 && bidx == 0) ? 16'h0000 : 16'($urandom);
        have = 1'b1;
        bidx++;
        if (bidx == flen) begin bidx = 0; fidx++; end
      end
      a_data = cur;
      a_valid = have && ($urandom % 4 != 0);
      #1;
      if (x_valid && x_ready) begin
        want = scr_q.pop_front();
        checks++;
        if (x_data !== want) begin
          errors++; $display("FAIL wide_scramble got=%h exp=%h", x_data, want);
        end
        if (!first_done) begin
          first_done = 1'b1;
          checks++;
          if (x_data !== 16'h3DB2) begin
            errors++; $display("FAIL wide_first got=%h exp=3db2", x_data);
          end
        end
      end
      if (b_valid) begin
        want = raw_q.pop_front();
        checks++;
        if (b_data !== want) begin
          errors++; $display("FAIL round_trip got=%h exp=%h", b_data, want);
        end
      end
      if (a_valid && a_ready) begin
        ref_wide(a_data, a_sop, e);
        scr_q.push_back(e);
        raw_q.push_back(a_data);
        have = 1'b0;
      end
    end
    a_valid = 1'b0;
    checks++;
    if (fidx != 1000 || raw_q.size() != 0) begin
      errors++;
      $display("FAIL round_trip_done frames=%0d left=%0d exp 1000/0",
               fidx, raw_q.size());
    end
  endtask

  task automatic test_random_handshake;
    logic [10:0] exp_q[$];
    logic [10:0] prev, want;
    logic [7:0]  e;
    logic        prev_stall, r0;
    int sent, got, cyc, stalls;
    prev_stall = 1'b0; prev = '0;
    sent = 0; got = 0; cyc = 0;
    while ((sent < 500 || exp_q.size() > 0) && cyc < 5000) begin
      cyc++;
      @(negedge clk);
      s_valid = (sent < 500) && ($urandom % 2 == 1);
      s_data = 8'($urandom);
      s_sop = ($urandom % 6 == 0);
      s_last = ($urandom % 2 == 1);
      s_par = ($urandom % 2 == 1);
      m_ready = (sent >= 500) || ($urandom % 2 == 1);
      #1;
      if (prev_stall) begin
        checks++;
        if (m_valid !== 1'b1 || {m_last, m_sop, m_par, m_data} !== prev) begin
          errors++;
          $display("FAIL stall_stable got v=%b %h exp v=1 %h", m_valid,
                   {m_last, m_sop, m_par, m_data}, prev);
        end
      end
`ifdef SCRAMBLER_PIPE_SKID_EN
      r0 = s_ready;
      m_ready = ~m_ready;
      #1;
      checks++;
      if (s_ready !== r0) begin
        errors++;
        $display("FAIL ready_comb got=%b exp=%b", s_ready, r0);
      end
      m_ready = ~m_ready;
      #1;
`else
      r0 = 1'b0;
`endif
      if (m_valid && m_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL dup_beat got=%h exp=none", m_data);
        end else begin
          want = exp_q.pop_front();
          if ({m_last, m_sop, m_par, m_data} !== want) begin
            errors++;
            $display("FAIL rand_beat got=%h exp=%h",
                     {m_last, m_sop, m_par, m_data}, want);
          end
        end
        got++;
      end
      if (s_valid && s_ready) begin
        ref_main(s_data, s_sop, e);
        exp_q.push_back({s_last, s_sop, s_par, e});
        sent++;
      end
      prev_stall = m_valid && !m_ready;
      prev = {m_last, m_sop, m_par, m_data};
    end
    s_valid = 1'b0;
    checks++;
    if (got != 500 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL rand_count got=%0d left=%0d exp 500/0", got, exp_q.size());
    end
    // Sustained full rate with downstream always ready.
    m_ready = 1'b1; stalls = 0;
    for (int i = 0; i <= 16; i++) begin
      @(negedge clk);
      if (i > 0) begin
        want = exp_q.pop_front();
        checks++;
        if (m_valid !== 1'b1 || m_data !== want[7:0]) begin
          errors++;
          $display("FAIL full_rate_b%0d got v=%b d=%h exp v=1 d=%h",
                   i - 1, m_valid, m_data, want[7:0]);
        end
      end
      if (i < 16) begin
        s_valid = 1'b1; s_data = 8'($urandom);
        s_sop = (i == 0); s_last = 1'b0; s_par = 1'b0;
        #1;
        if (s_ready !== 1'b1) stalls++;
        ref_main(s_data, s_sop, e);
        exp_q.push_back({3'b0, e});
      end else begin
        s_valid = 1'b0; s_sop = 1'b0;
      end
    end
    checks++;
    if (stalls != 0) begin
      errors++; $display("FAIL full_rate_stalls got=%0d exp=0", stalls);
    end
  endtask

  task automatic test_reset_mid;
    logic [7:0] e;
    @(negedge clk);
    m_ready = 1'b0;
    s_valid = 1'b1; s_data = 8'h55; s_sop = 1'b1;
    @(negedge clk);
    s_valid = 1'b0; s_sop = 1'b0;
    checks++;
    if (m_valid !== 1'b1) begin
      errors++; $display("FAIL rstmid_stall got=%b exp=1", m_valid);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (m_valid !== 1'b0 || m_data !== 8'h00) begin
      errors++;
      $display("FAIL rstmid_flush got v=%b d=%h exp v=0 d=00", m_valid, m_data);
    end
    @(negedge clk);
    rst = 1'b0;
    st_ref = SEED_I;
    m_ready = 1'b1;
    s_valid = 1'b1; s_data = 8'h00; s_sop = 1'b0;
    ref_main(s_data, s_sop, e);
    @(negedge clk);
    s_valid = 1'b0;
    checks++;
    if (m_valid !== 1'b1 || m_data !== 8'hB2 || m_data !== e) begin
      errors++;
      $display("FAIL rstmid_noseed got v=%b d=%h exp v=1 d=b2", m_valid, m_data);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sop_mid();
    test_parity_bypass();
    test_round_trip();
    test_random_handshake();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
